instr_mem_loader: RTL and testbench

//  Instruction memory plus boot loader: the responder side of the CPU fetch interface (PC, ROM_enable -> ROM_data).

---
 rtl/instr_mem_loader.sv | 137 +++++++++++++
 tb/tb_instr_mem_loader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory with a byte-stream boot loader: bytes pair into 16-bit words,
// the CPU is held until a full image is loaded, then PC fetches are served.
module instr_mem_loader #(
  parameter int unsigned         ADDR_W    = 6,
  parameter int unsigned         DATA_W    = 16,
  parameter int unsigned         DEPTH     = 64,
  parameter logic [DATA_W-1:0]   FILL_WORD = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] PC,
  input  logic              ROM_enable,
  output logic [DATA_W-1:0] ROM_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {EMPTY, HI, LO, RUN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    loaded_q, loaded_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          hi_q, hi_d;
  logic                hold_d, done_d, err_d, ready_d;
  logic [DATA_W-1:0]   rom_d;
  logic                wr_en_c;
  logic                xfer_c;
  logic                bad_count_c;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign xfer_c      = byte_valid & byte_ready;
  assign bad_count_c = (load_count == '0) || (load_count > CNT_W'(DEPTH));

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    addr_d   = addr_q;
    hi_d     = hi_q;
    hold_d   = cpu_hold;
    done_d   = 1'b0;
    err_d    = load_error;
    rom_d    = (state_q == RUN) ? ROM_data : '0;
    wr_en_c  = 1'b0;

    case (state_q)
      EMPTY, RUN: begin
        if (state_q == RUN && ROM_enable) begin
          rom_d = ({1'b0, PC} < loaded_q) ? mem[PC] : FILL_WORD;
        end
        if (load_start) begin
          if (bad_count_c) begin
            err_d = 1'b1;
          end else begin
            err_d    = 1'b0;
            cnt_d    = load_count;
            addr_d   = '0;
            loaded_d = '0;
            hold_d   = 1'b1;
            rom_d    = '0;
            state_d  = HI;
          end
        end
      end
      HI: begin
        if (xfer_c) begin
          hi_d    = byte_data;
          state_d = LO;
        end
      end
      LO: begin
        if (xfer_c) begin
          wr_en_c = 1'b1;
          // cnt never exceeds DEPTH, so the last write lands at DEPTH-1 without wrapping
          if ({1'b0, addr_q} == cnt_q - CNT_W'(1)) begin
            loaded_d = cnt_q;
            hold_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = RUN;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = HI;
          end
        end
      end
      default: state_d = EMPTY;
    endcase

    ready_d = (state_d == HI) || (state_d == LO);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      cnt_q      <= '0;
      loaded_q   <= '0;
      addr_q     <= '0;
      hi_q       <= '0;
      cpu_hold   <= 1'b1;
      byte_ready <= 1'b0;
      ROM_data   <= '0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      loaded_q   <= loaded_d;
      addr_q     <= addr_d;
      hi_q       <= hi_d;
      cpu_hold   <= hold_d;
      byte_ready <= ready_d;
      ROM_data   <= rom_d;
      load_done  <= done_d;
      load_error <= err_d;
    end
  end

  // Storage is deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[addr_q] <= DATA_W'({hi_q, byte_data});
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader: byte-stream image loads and fetches
// checked against an image-level reference model.
module tb_instr_mem_loader;

  localparam logic [15:0] FILL = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [6:0]  load_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [5:0]  PC;
  logic        ROM_enable;
  logic [15:0] ROM_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  instr_mem_loader dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_count(load_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .PC(PC), .ROM_enable(ROM_enable), .ROM_data(ROM_data),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the loaded image, its length, and the last fetched word
  logic [15:0] model_mem [64];
  int          model_loaded = 0;
  bit          model_run = 0;
  logic [15:0] model_rom = 16'h0;
  logic [15:0] stim_words [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [5:0] pc, input bit en);
    load_start = 1'b0;
    PC         = pc;
    ROM_enable = en;
    tick();
    if (model_run && en) model_rom = (int'(pc) < model_loaded) ? model_mem[pc] : FILL;
    check($sformatf("fetch pc=%0d en=%0d", pc, en), 32'(ROM_data), 32'(model_rom));
    ROM_enable = 1'b0;
  endtask

  task automatic bad_start(input logic [6:0] cnt);
    load_start = 1'b1;
    load_count = cnt;
    ROM_enable = 1'b0;
    tick();
    load_start = 1'b0;
    check($sformatf("load_error cnt=%0d", cnt), 32'(load_error), 32'd1);
    check("rom kept on bad start", 32'(ROM_data), 32'(model_rom));
    check("hold kept on bad start", 32'(cpu_hold), 32'(!model_run));
    check("ready idle on bad start", 32'(byte_ready), 32'd0);
  endtask

  // Load stim_words[0..n-1]; optionally random valid gaps, a stray load_start
  // while a low byte is pending, or an async reset after abort_at bytes.
  task automatic load_image(input int n, input bit rand_valid, input bit inject, input int abort_at);
    int  idx = 0;
    int  budget = 0;
    int  early_done = 0;
    bit  injected = 0;
    bit  xfer;
    logic [7:0] b;

    load_start = 1'b1;
    load_count = 7'(n);
    byte_valid = 1'b0;
    ROM_enable = 1'b0;
    tick();
    load_start = 1'b0;
    model_run  = 0;
    model_rom  = 16'h0;
    check("hold after start", 32'(cpu_hold), 32'd1);
    check("ready after start", 32'(byte_ready), 32'd1);
    check("error cleared", 32'(load_error), 32'd0);
    check("rom zero in load", 32'(ROM_data), 32'd0);

    while (idx < 2 * n) begin
      if (abort_at > 0 && idx == abort_at) begin
        byte_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("reset hold", 32'(cpu_hold), 32'd1);
        check("reset ready", 32'(byte_ready), 32'd0);
        check("reset rom", 32'(ROM_data), 32'd0);
        #3 reset = 1'b1;
        model_loaded = 0;
        return;
      end
      if (budget++ > 4000) begin
        check("load budget expired", 32'(idx), 32'(2 * n));
        return;
      end
      b          = (idx % 2 == 0) ? stim_words[idx / 2][15:8] : stim_words[idx / 2][7:0];
      byte_data  = b;
      byte_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      ROM_enable = 1'($urandom_range(0, 1));
      PC         = 6'($urandom);
      if (inject && idx == 1 && !injected) begin
        load_start = 1'b1;
        load_count = 7'($urandom_range(1, 64));
        injected   = 1;
      end else begin
        load_start = 1'b0;
      end
      if (load_done) early_done++;
      xfer = byte_valid && byte_ready;
      tick();
      if (xfer) idx++;
    end
    load_start = 1'b0;
    byte_valid = 1'b0;
    ROM_enable = 1'b0;
    for (int i = 0; i < n; i++) model_mem[i] = stim_words[i];
    model_loaded = n;
    model_run    = 1;
    check("no early load_done", 32'(early_done), 32'd0);
    check("load_done pulse", 32'(load_done), 32'd1);
    check("hold released", 32'(cpu_hold), 32'd0);
    check("ready dropped", 32'(byte_ready), 32'd0);
    tick();
    check("load_done one cycle", 32'(load_done), 32'd0);
  endtask

  initial begin
    reset      = 1'b0;
    load_start = 1'b0;
    load_count = 7'd0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    PC         = 6'd0;
    ROM_enable = 1'b0;
    #12;
    check("rst hold", 32'(cpu_hold), 32'd1);
    check("rst ready", 32'(byte_ready), 32'd0);
    check("rst rom", 32'(ROM_data), 32'd0);
    check("rst done", 32'(load_done), 32'd0);
    check("rst error", 32'(load_error), 32'd0);
    reset = 1'b1;
    tick();
    fetch(6'd0, 1'b1);

    // Directed three-word image
    stim_words[0] = 16'h1234;
    stim_words[1] = 16'h5678;
    stim_words[2] = 16'h9ABC;
    load_image(3, 0, 0, 0);
    fetch(6'd1, 1'b1);
    check("pc1 word", 32'(ROM_data), 32'h5678);
    fetch(6'd2, 1'b0);
    fetch(6'd5, 1'b1);
    fetch(6'd0, 1'b1);
    fetch(6'd2, 1'b1);

    // Out-of-range counts
    bad_start(7'd0);
    bad_start(7'd65);
    bad_start(7'd127);
    fetch(6'd2, 1'b1);

    // Full-depth image with random valid gaps
    for (int i = 0; i < 64; i++) stim_words[i] = 16'($urandom);
    load_image(64, 1, 0, 0);
    for (int i = 0; i < 64; i++) fetch(6'(i), 1'b1);

    // Reload from RUN with a stray load_start while a low byte is pending
    for (int i = 0; i < 5; i++) stim_words[i] = 16'($urandom);
    load_image(5, 1, 1, 0);
    for (int i = 0; i < 30; i++) fetch(6'($urandom), 1'($urandom_range(0, 1)));

    // Reset after the third byte of a load, then a full reload
    for (int i = 0; i < 4; i++) stim_words[i] = 16'($urandom);
    load_image(4, 0, 0, 3);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) fetch(6'(i), 1'b1);
    check("hold after aborted load", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < 7; i++) stim_words[i] = 16'($urandom);
    load_image(7, 1, 0, 0);
    for (int i = 0; i < 30; i++) fetch(6'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
